sc_stream_to_binary: RTL
========================

# sc_stream_to_binary

Stochastic-to-binary converter: the receiving end of the stochastic number generator chain that the LFSR random source feeds. It counts the ones in a unipolar stochastic bitstream over a fixed window of 2^WIDTH accepted bits and presents the count as a binary value through a valid/ready handshake. WIDTH matches the generator's LFSR width, so one window equals one full LFSR period (including the added all-zero state). It sits at the output of ReSC-style stochastic datapaths, ahead of binary post-processing.

## Interface
- WIDTH, 10, LFSR/window width; window length N = 2^WIDTH accepted bits
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high
- restart  input  1  synchronous clear to IDLE; highest priority after reset
- start  input  1  begin a conversion window; honoured only in IDLE or on the DONE hand-off cycle
- bit_in  input  1  stochastic bitstream sample
- bit_valid  input  1  bit_in is accepted this cycle (RUN only)
- busy  output  1  high in RUN
- result  output  WIDTH+1  ones count, range 0..2^WIDTH
- result_valid  output  1  result is final and held stable
- result_ready  input  1  consumer accepts result

## Operation
- States: IDLE, RUN, DONE.
- IDLE: the counters are held at zero. start=1 -> RUN.
- RUN: on each cycle with bit_valid=1:
  - ones_cnt += bit_in
  - sample_cnt += 1
  - Cycles with bit_valid=0 change nothing.
  - The accepted bit with sample_cnt = N-1 is the last bit. That cycle, result is loaded with ones_cnt + bit_in, and the state goes to DONE.
- DONE: result_valid=1, and result stays constant.
  - result_ready=1 -> IDLE.
  - result_ready=1 and start=1 in the same cycle -> RUN directly, with the counters cleared (back-to-back windows).
  - bit_valid is ignored outside RUN.
- start is ignored in RUN and in DONE while result_ready=0.
- restart=1 (any state):
  - Next state is IDLE.
  - sample_cnt, ones_cnt and result clear to 0.
  - result_valid drops.
  - Overrides a simultaneous start or last bit.
- Widths:
  - sample_cnt is WIDTH bits and wraps only by the terminal-count transition.
  - ones_cnt and result are WIDTH+1 bits, so all-ones gives 2^WIDTH exactly, with no saturation or overflow.
- Reset values: state IDLE; counters 0; result 0; result_valid 0; busy 0.
- Reset mid-window discards the partial count.

## Timing
- start sampled at cycle t -> busy=1 from t+1. The first bit can be accepted at t+1.
- Last accepted bit at cycle t -> result_valid=1 and the final result visible from t+1. busy=0 from t+1.
- Minimum conversion: N+1 cycles from start to result_valid with bit_valid held high.
- The back-to-back hand-off adds no idle cycle: the next window's first bit can be accepted the cycle after the handshake.
- All outputs come directly from registers, with no combinational path from inputs.

## Structure
- Shared package `sc_pkg`:
  - state enum type (IDLE/RUN/DONE)
  - helper constant for window length `1 << WIDTH`, shared with the LFSR/SNG blocks
- The package must not duplicate the generator's seed constants.
- One natural sub-module, `sc_window_counter`:
  - WIDTH-bit sample counter with enable, sync clear and terminal-count flag
  - reusable by the SNG side for period tracking
- The FSM, ones accumulator and result register stay in the top module.

## Test plan
- WIDTH=10, start, then 1024 cycles of bit_in=1 with bit_valid=1:
  - result=1024 and result_valid exactly at cycle 1025 after start
  - busy low from then on
- WIDTH=10, alternating 1/0 for 1024 bits -> result=512. All zeros -> result=0.
- WIDTH=4, bit_valid toggled every other cycle with bit_in=1:
  - only 16 accepted bits count, result=16
  - invalid cycles carrying bit_in=1 are not counted
- WIDTH=4, result_ready held low for 5 cycles in DONE, with start pulses and bit_valid during DONE:
  - result stable, no new window
  - then result_ready=1 with start=1 -> RUN next cycle, and the second window counts from 0
- WIDTH=4, restart asserted after 7 accepted bits, and separately on the last-bit cycle:
  - IDLE next cycle, counters 0, no result_valid
  - a following window produces a correct independent count
- WIDTH=10, bitstream driven by the 10-bit LFSR compared against constant 300 (SNG):
  - over one full LFSR period, result=300 exactly
  - async reset mid-window clears all outputs immediately

Source files
------------

// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sc_pkg
// Brief    : Shared types and helpers for the stochastic computing chain
//            (LFSR / SNG / stream-to-binary converter).
// Revision : 1.0 - initial release
// ============================================================================
package sc_pkg;

    // Converter control states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sc_state_t;

    // Default LFSR / window width used across the chain.
    localparam int C_SC_DEFAULT_WIDTH = 10;

    // Window length: one full LFSR period including the all-zero state.
    function automatic int unsigned sc_window_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_window_counter.sv
`default_nettype none
// ============================================================================
// Module   : sc_window_counter
// Brief    : WIDTH-bit sample counter with enable, synchronous clear and a
//            terminal-count flag marking the last sample of a window.
// Revision : 1.0 - initial release
// ============================================================================
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int WIDTH = C_SC_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    // Index of the last sample in a window (N-1).
    localparam logic [WIDTH-1:0] c_last = WIDTH'(sc_window_len(WIDTH) - 1);

    logic [WIDTH-1:0] r_count;

    // Sample counter; wraps to zero naturally after the terminal sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count    = r_count;
    assign terminal = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/sc_stream_to_binary.sv
`default_nettype none
// ============================================================================
// Module   : sc_stream_to_binary
// Brief    : Counts ones in a unipolar stochastic bitstream over a window of
//            2^WIDTH accepted bits and presents the count via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module sc_stream_to_binary
    import sc_pkg::*;
#(
    parameter int WIDTH = C_SC_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    input  logic             result_ready
);

    sc_state_t        r_state;
    sc_state_t        w_state_next;
    logic [WIDTH:0]   r_ones;
    logic [WIDTH:0]   r_result;
    logic             r_busy;
    logic             r_result_valid;
    logic [WIDTH-1:0] w_sample_cnt;
    logic             w_terminal;
    logic             w_accept;
    logic             w_last;
    logic             w_cnt_clear;
    logic [WIDTH:0]   w_bit_ext;

    assign w_accept    = (r_state == ST_RUN) && bit_valid;
    assign w_last      = w_accept && w_terminal;
    // Counter is held at zero whenever no window is in progress.
    assign w_cnt_clear = restart || (r_state != ST_RUN);
    assign w_bit_ext   = {{WIDTH{1'b0}}, bit_in};

    sc_window_counter #(
        .WIDTH(WIDTH)
    ) u_window_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_cnt_clear),
        .enable   (w_accept),
        .count    (w_sample_cnt),
        .terminal (w_terminal)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; restart overrides start and the last-bit transition.
    always_comb begin
        w_state_next = r_state;
        if (restart) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) w_state_next = ST_RUN;
                ST_RUN:  if (w_last) w_state_next = ST_DONE;
                ST_DONE: begin
                    if (result_ready) begin
                        w_state_next = start ? ST_RUN : ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Ones accumulator; cleared outside RUN and after the last bit so each
    // window (including a back-to-back one) starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ones <= '0;
        end else if (restart || (r_state != ST_RUN) || w_last) begin
            r_ones <= '0;
        end else if (w_accept) begin
            r_ones <= r_ones + w_bit_ext;
        end
    end

    // Result register: captures the final count including the last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
        end else if (restart) begin
            r_result <= '0;
        end else if (w_last) begin
            r_result <= r_ones + w_bit_ext;
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_busy         <= (w_state_next == ST_RUN);
            r_result_valid <= (w_state_next == ST_DONE);
        end
    end

    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
`default_nettype wire
